// File: rtl/instr_buffer_if.sv
// Fetch-to-decode handshake bundle for instr_buffer.
// master: frontend/dispatch side (drives fetch group and accept vector).
// slave : the buffer itself.
interface instr_buffer_if #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int EXCP_W       = 16
);
  logic [FETCH_WIDTH-1:0]              frontend_valid_i;
  logic [FETCH_WIDTH-1:0][31:0]        frontend_pc_i;
  logic [FETCH_WIDTH-1:0][31:0]        frontend_instr_i;
  logic [FETCH_WIDTH-1:0]              frontend_excp_i;
  logic [FETCH_WIDTH-1:0][EXCP_W-1:0]  frontend_excp_num_i;
  logic                                frontend_stallreq_o;
  logic [DECODE_WIDTH-1:0]             backend_accept_i;
  logic [DECODE_WIDTH-1:0]             backend_valid_o;
  logic [DECODE_WIDTH-1:0][31:0]       backend_pc_o;
  logic [DECODE_WIDTH-1:0][31:0]       backend_instr_o;
  logic [DECODE_WIDTH-1:0]             backend_excp_o;
  logic [DECODE_WIDTH-1:0][EXCP_W-1:0] backend_excp_num_o;

  modport master (
    output frontend_valid_i, frontend_pc_i, frontend_instr_i, frontend_excp_i,
           frontend_excp_num_i, backend_accept_i,
    input  frontend_stallreq_o, backend_valid_o, backend_pc_o, backend_instr_o,
           backend_excp_o, backend_excp_num_o
  );

  modport slave (
    input  frontend_valid_i, frontend_pc_i, frontend_instr_i, frontend_excp_i,
           frontend_excp_num_i, backend_accept_i,
    output frontend_stallreq_o, backend_valid_o, backend_pc_o, backend_instr_o,
           backend_excp_o, backend_excp_num_o
  );
endinterface

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and decode/dispatch.
// Takes up to FETCH_WIDTH sparse-valid instructions per cycle (compacted at
// tail), presents the oldest DECODE_WIDTH entries, pops the contiguous
// accepted prefix. Flush empties it.
// Optional macro IB_PERF_CNT_EN adds saturating full/empty cycle counters.

// Per-slot read gate: drives zeros whenever the slot holds no entry.
module ib_rd_slot #(
  parameter int EXCP_W = 16
) (
  input  logic              vld,
  input  logic [31:0]       ent_pc,
  input  logic [31:0]       ent_instr,
  input  logic              ent_excp,
  input  logic [EXCP_W-1:0] ent_excp_num,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic              excp_o,
  output logic [EXCP_W-1:0] excp_num_o
);
  assign pc_o       = vld ? ent_pc       : '0;
  assign instr_o    = vld ? ent_instr    : '0;
  assign excp_o     = vld & ent_excp;
  assign excp_num_o = vld ? ent_excp_num : '0;
endmodule

module instr_buffer #(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int EXCP_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  instr_buffer_if.slave            ib,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef IB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_full_cycles_o,
  output logic [31:0]              perf_empty_cycles_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              excp;
    logic [EXCP_W-1:0] excp_num;
  } ib_entry_t;

  ib_entry_t mem [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW-1:0] n_push, n_pop;
  logic          stall, push_ok, run;
  logic [PW-1:0] off;
  logic [FETCH_WIDTH-1:0][PW-1:0] wr_idx;

  logic [DECODE_WIDTH-1:0]             slot_vld;
  logic [DECODE_WIDTH-1:0][31:0]       bk_pc, bk_instr;
  logic [DECODE_WIDTH-1:0]             bk_excp;
  logic [DECODE_WIDTH-1:0][EXCP_W-1:0] bk_excp_num;

  // Stall uses only the registered occupancy; same-cycle pops are not credited.
  assign stall   = (CW'(DEPTH) - count) < CW'(FETCH_WIDTH);
  assign push_ok = ~stall & ~flush;
  assign count_o = count;
  assign ib.frontend_stallreq_o = stall;

  // Compaction: each valid slot lands at tail + (number of valid slots below it).
  always_comb begin
    off    = '0;
    n_push = '0;
    wr_idx = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail + off;
      if (ib.frontend_valid_i[i]) begin
        off    = off + 1'b1;
        n_push = n_push + 1'b1;
      end
    end
    if (stall) n_push = '0;
  end

  // Pop count is the contiguous accepted-and-valid run starting at slot 0.
  always_comb begin
    n_pop = '0;
    run   = 1'b1;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (run && ib.backend_accept_i[i] && slot_vld[i]) n_pop = n_pop + 1'b1;
      else                                              run   = 1'b0;
    end
  end

  // Entry storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (push_ok && ib.frontend_valid_i[i]) begin
        mem[wr_idx[i]].pc       <= ib.frontend_pc_i[i];
        mem[wr_idx[i]].instr    <= ib.frontend_instr_i[i];
        mem[wr_idx[i]].excp     <= ib.frontend_excp_i[i];
        mem[wr_idx[i]].excp_num <= ib.frontend_excp_num_i[i];
      end
    end
  end

  // Pointer/occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_pop[PW-1:0];
      tail  <= tail + n_push[PW-1:0];
      count <= count + n_push - n_pop;
    end
  end

  // Read side: slot i shows entry (head+i) mod DEPTH, zeroed when beyond count.
  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_slot
    logic [PW-1:0] rd_idx;
    assign rd_idx      = head + PW'(i);
    assign slot_vld[i] = count > CW'(i);
    ib_rd_slot #(.EXCP_W(EXCP_W)) u_slot (
      .vld          (slot_vld[i]),
      .ent_pc       (mem[rd_idx].pc),
      .ent_instr    (mem[rd_idx].instr),
      .ent_excp     (mem[rd_idx].excp),
      .ent_excp_num (mem[rd_idx].excp_num),
      .pc_o         (bk_pc[i]),
      .instr_o      (bk_instr[i]),
      .excp_o       (bk_excp[i]),
      .excp_num_o   (bk_excp_num[i])
    );
  end

  assign ib.backend_valid_o    = slot_vld;
  assign ib.backend_pc_o       = bk_pc;
  assign ib.backend_instr_o    = bk_instr;
  assign ib.backend_excp_o     = bk_excp;
  assign ib.backend_excp_num_o = bk_excp_num;

`ifdef IB_PERF_CNT_EN
  // Saturating stall/empty cycle counters; survive flush, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cycles_o  <= '0;
      perf_empty_cycles_o <= '0;
    end else begin
      if (stall && perf_full_cycles_o != '1)
        perf_full_cycles_o <= perf_full_cycles_o + 32'd1;
      if (count == '0 && perf_empty_cycles_o != '1)
        perf_empty_cycles_o <= perf_empty_cycles_o + 32'd1;
    end
  end
`endif

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_pop_le_count: assert property (@(posedge clk) disable iff (!rst_n)
    n_pop <= count);
  a_no_push_stall: assert property (@(posedge clk) disable iff (!rst_n)
    stall |-> (n_push == '0));
endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: compaction, stall/drop, pop rules,
// wrap-around, flush priority, async reset.
module tb_instr_buffer;
  localparam int DEPTH = 16, FW = 4, DW = 2, EW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [$clog2(DEPTH):0] count_o;
  int vecs = 0;
  int errs = 0;

  instr_buffer_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .EXCP_W(EW)) ib ();

`ifdef IB_PERF_CNT_EN
  logic [31:0] perf_full, perf_empty;
`endif

  instr_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .EXCP_W(EW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .ib      (ib),
    .count_o (count_o)
`ifdef IB_PERF_CNT_EN
    ,
    .perf_full_cycles_o  (perf_full),
    .perf_empty_cycles_o (perf_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one fetch group (PCs base, base+4, ...) and accept vector for one edge.
  task automatic push(input logic [FW-1:0] v, input logic [31:0] base, input logic [DW-1:0] acc);
    ib.frontend_valid_i = v;
    for (int i = 0; i < FW; i++) begin
      ib.frontend_pc_i[i]    = base + 32'(4 * i);
      ib.frontend_instr_i[i] = ~(base + 32'(4 * i));
    end
    ib.backend_accept_i = acc;
    step();
    ib.frontend_valid_i    = '0;
    ib.backend_accept_i    = '0;
    ib.frontend_excp_i     = '0;
    ib.frontend_excp_num_i = '0;
  endtask

  task automatic pop(input logic [DW-1:0] acc);
    ib.backend_accept_i = acc;
    step();
    ib.backend_accept_i = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ib.frontend_valid_i    = '0;
    ib.frontend_pc_i       = '0;
    ib.frontend_instr_i    = '0;
    ib.frontend_excp_i     = '0;
    ib.frontend_excp_num_i = '0;
    ib.backend_accept_i    = '0;
    #1;
    chk("rst_valid", ib.backend_valid_o, 2'b00);
    chk("rst_count", count_o, 0);
    chk("rst_stall", ib.frontend_stallreq_o, 1'b0);
    chk("rst_pc0",   ib.backend_pc_o[0], 32'h0);
    #11 rst_n = 1'b1;

    // Full group, no accept
    push(4'b1111, 32'h1c000000, 2'b00);
    chk("full_valid", ib.backend_valid_o, 2'b11);
    chk("full_pc0",   ib.backend_pc_o[0], 32'h1c000000);
    chk("full_pc1",   ib.backend_pc_o[1], 32'h1c000004);
    chk("full_ins0",  ib.backend_instr_o[0], 32'he3ffffff);
    chk("full_cnt",   count_o, 4);
    do_flush();
    chk("flush_cnt",  count_o, 0);
    chk("flush_vld",  ib.backend_valid_o, 2'b00);

    // Sparse group compacts; slot 3 carries an exception
    ib.frontend_excp_i        = 4'b1000;
    ib.frontend_excp_num_i[3] = 16'h0abc;
    ib.frontend_excp_num_i[1] = 16'h1234;
    push(4'b1010, 32'h100, 2'b00);
    chk("sp_pc0",   ib.backend_pc_o[0], 32'h104);
    chk("sp_pc1",   ib.backend_pc_o[1], 32'h10c);
    chk("sp_cnt",   count_o, 2);
    chk("sp_excp",  ib.backend_excp_o, 2'b10);
    chk("sp_enum0", ib.backend_excp_num_o[0], 16'h1234);
    chk("sp_enum1", ib.backend_excp_num_o[1], 16'h0abc);

    // Pop rules
    pop(2'b10);
    chk("acc10_cnt", count_o, 2);
    pop(2'b01);
    chk("acc01_cnt", count_o, 1);
    chk("acc01_vld", ib.backend_valid_o, 2'b01);
    chk("acc01_pc0", ib.backend_pc_o[0], 32'h10c);
    chk("acc01_pc1", ib.backend_pc_o[1], 32'h0);
    pop(2'b11);
    chk("acc11_cnt", count_o, 0);
    chk("acc11_vld", ib.backend_valid_o, 2'b00);

    // Fill to 13 -> stall, dropped group, pop relieves stall
    push(4'b1111, 32'h200, 2'b00);
    push(4'b1111, 32'h210, 2'b00);
    push(4'b1111, 32'h220, 2'b00);
    push(4'b0001, 32'h230, 2'b00);
    chk("f13_cnt",   count_o, 13);
    chk("f13_stall", ib.frontend_stallreq_o, 1'b1);
    push(4'b1111, 32'h900, 2'b00);
    chk("drop_cnt",  count_o, 13);
    chk("drop_pc0",  ib.backend_pc_o[0], 32'h200);
    pop(2'b11);
    chk("p11_cnt",   count_o, 11);
    chk("p11_stall", ib.frontend_stallreq_o, 1'b0);
    chk("p11_pc0",   ib.backend_pc_o[0], 32'h208);
    chk("p11_pc1",   ib.backend_pc_o[1], 32'h20c);

    // Flush beats simultaneous push and pop
    flush = 1'b1;
    push(4'b1111, 32'h800, 2'b11);
    flush = 1'b0;
    chk("fp_cnt", count_o, 0);
    chk("fp_vld", ib.backend_valid_o, 2'b00);

    // Wrap-around: fill to 16, drain past the end, straddle index 15 -> 0
    push(4'b1111, 32'h300, 2'b00);
    push(4'b1111, 32'h310, 2'b00);
    push(4'b1111, 32'h320, 2'b00);
    chk("w12_stall", ib.frontend_stallreq_o, 1'b0);
    push(4'b1111, 32'h330, 2'b00);
    chk("w16_cnt",   count_o, 16);
    chk("w16_stall", ib.frontend_stallreq_o, 1'b1);
    chk("w16_pc0",   ib.backend_pc_o[0], 32'h300);
    pop(2'b11);
    chk("w14_cnt",   count_o, 14);
    chk("w14_pc0",   ib.backend_pc_o[0], 32'h308);
    for (int k = 0; k < 6; k++) pop(2'b11);
    chk("w2_cnt",    count_o, 2);
    chk("w2_pc0",    ib.backend_pc_o[0], 32'h338);
    chk("w2_pc1",    ib.backend_pc_o[1], 32'h33c);
    push(4'b1111, 32'h340, 2'b01);
    chk("wx_cnt",    count_o, 5);
    chk("wx_pc0",    ib.backend_pc_o[0], 32'h33c);
    chk("wx_pc1",    ib.backend_pc_o[1], 32'h340);
    chk("wx_ins1",   ib.backend_instr_o[1], 32'hfffffcbf);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("ar_vld",   ib.backend_valid_o, 2'b00);
    chk("ar_cnt",   count_o, 0);
    chk("ar_pc0",   ib.backend_pc_o[0], 32'h0);
    chk("ar_stall", ib.frontend_stallreq_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
